// File: rtl/mem_load_ctrl_pkg.sv
// Shared definitions for the A-side and B-side matrix loaders.
// Holds the loader FSM encoding and the skew-buffer stream length.
package mem_load_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_READY  = 2'd1,
      ST_STREAM = 2'd2
   } ld_state_t;

   // A DIM x DIM skewed matrix drains through the array in 3*DIM-2 shift cycles.
   function automatic int stream_len(input int dim);
      return 3 * dim - 2;
   endfunction

endpackage

// File: rtl/mem_load_ctrl.sv
// Row loader feeding the A-matrix skew buffer (memA).
// Writes DIM rows, waits for start, then drives shift enables for one drain pass.
module mem_load_ctrl
   import mem_load_ctrl_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clear,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [DIM*BITS_AB-1:0]      in_data,
   input  logic                        start,
   output logic                        busy,
   output logic                        done,
   output logic                        mem_WrEn,
   output logic [$clog2(DIM)-1:0]      mem_Arow,
   output logic signed [BITS_AB-1:0]   mem_Ain [DIM],
   output logic                        mem_en
);

   localparam int SLEN = stream_len(DIM);
   localparam int RW   = $clog2(DIM);
   localparam int SW   = $clog2(SLEN);
   localparam logic [RW-1:0] RLAST = RW'(DIM - 1);
   localparam logic [SW-1:0] SLAST = SW'(SLEN - 1);

   ld_state_t             state, nstate;
   logic [RW-1:0]         rcnt;
   logic [SW-1:0]         scnt;
   logic                  accept;
   logic                  last_row;
   logic                  last_beat;
   logic signed [BITS_AB-1:0] row [DIM];

   for (genvar g = 0; g < DIM; g++) begin : g_unpack
      assign row[g] = in_data[g*BITS_AB +: BITS_AB];
   end

   // Clear blocks acceptance in the same cycle so an aborted load never writes.
   assign in_ready  = (state == ST_IDLE) && !clear && !rst;
   assign accept    = in_valid && in_ready;
   assign last_row  = accept && (rcnt == RLAST);
   assign last_beat = (state == ST_STREAM) && (scnt == SLAST);
   assign busy      = (state != ST_IDLE);
   assign mem_en    = (state == ST_STREAM);

   always_comb begin
      nstate = state;
      if (clear) begin
         nstate = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (last_row)  nstate = ST_READY;
            ST_READY:  if (start)     nstate = ST_STREAM;
            ST_STREAM: if (last_beat) nstate = ST_IDLE;
            default:                  nstate = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         rcnt     <= '0;
         scnt     <= '0;
         done     <= 1'b0;
         mem_WrEn <= 1'b0;
         mem_Arow <= '0;
         for (int j = 0; j < DIM; j++) mem_Ain[j] <= '0;
      end else begin
         state <= nstate;
         done  <= last_beat && !clear;

         if (clear)         rcnt <= '0;
         else if (last_row) rcnt <= '0;
         else if (accept)   rcnt <= rcnt + RW'(1);

         if (clear || state != ST_STREAM || last_beat) scnt <= '0;
         else                                          scnt <= scnt + SW'(1);

         mem_WrEn <= accept;
         if (accept) begin
            mem_Arow <= rcnt;
            for (int j = 0; j < DIM; j++) mem_Ain[j] <= row[j];
         end
      end
   end

   // Writes land in the first READY cycle at the latest, before any stream can start.
   a_wr_en_excl: assert property (@(posedge clk) disable iff (rst) !(mem_WrEn && mem_en));
   a_done_pulse: assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_mem_load_ctrl.sv
// Directed bench for mem_load_ctrl: stimulus queues expected writes, a negedge
// monitor pops and compares them and tallies stream enables and done pulses.
module tb_mem_load_ctrl;

   localparam int BITS_AB = 8;
   localparam int DIM     = 8;

   typedef struct {
      logic [2:0]  arow;
      logic [63:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst, clear, in_valid, start;
   logic in_ready, busy, done, mem_WrEn, mem_en;
   logic [63:0] in_data;
   logic [2:0]  mem_Arow;
   logic signed [7:0] mem_Ain [DIM];

   int vectors = 0;
   int miscompares = 0;
   int en_total, en_runs, done_cnt, wr_total;
   logic prev_en = 1'b0;
   wr_t exp_q [$];

   always #5 clk = ~clk;

   mem_load_ctrl #(.BITS_AB(BITS_AB), .DIM(DIM)) dut (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .start(start), .busy(busy), .done(done), .mem_WrEn(mem_WrEn),
      .mem_Arow(mem_Arow), .mem_Ain(mem_Ain), .mem_en(mem_en)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] mk_row(input int r);
      logic [63:0] d;
      for (int j = 0; j < DIM; j++) d[j*8 +: 8] = 8'(r*8 + j);
      return d;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_row(input logic [63:0] d, input bit expect_acc, input int arow);
      wr_t w;
      if (expect_acc) begin
         w.arow = 3'(arow);
         w.data = d;
         exp_q.push_back(w);
      end
      in_valid = 1'b1;
      in_data  = d;
      idle(1);
      in_valid = 1'b0;
   endtask

   task automatic clr_counts();
      en_total = 0; en_runs = 0; done_cnt = 0; wr_total = 0;
   endtask

   task automatic check_loaded(input string tag);
      idle(1);
      @(negedge clk);
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_writes"}, 64'(wr_total), 64'd8);
      idle(1);
   endtask

   task automatic do_stream(input string tag, input int exp_en);
      clr_counts();
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(exp_en + 4);
      @(negedge clk);
      chk({tag, "_en_cycles"}, 64'(en_total), 64'(exp_en));
      chk({tag, "_en_runs"}, 64'(en_runs), 64'd1);
      chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      idle(1);
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_WrEn) begin
            wr_total++;
            if (exp_q.size() == 0) begin
               chk("unexpected_write", 64'(mem_Arow), 64'hDEAD);
            end else begin
               wr_t w;
               logic [63:0] act;
               w = exp_q.pop_front();
               for (int j = 0; j < DIM; j++) act[j*8 +: 8] = mem_Ain[j];
               chk("wr_arow", 64'(mem_Arow), 64'(w.arow));
               chk("wr_data", act, w.data);
            end
         end
         if (mem_WrEn || mem_en) chk("wr_en_excl", 64'(mem_WrEn && mem_en), 64'd0);
         if (mem_en) begin
            en_total++;
            if (!prev_en) en_runs++;
         end
         if (done) begin
            done_cnt++;
            chk("done_after_en", 64'(prev_en), 64'd1);
            chk("ready_at_done", 64'(in_ready), 64'd1);
         end
         prev_en = mem_en;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; start = 1'b0; in_data = '0;
      clr_counts();
      idle(3);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_wren", 64'(mem_WrEn), 64'd0);
      chk("rst_en", 64'(mem_en), 64'd0);
      chk("rst_arow", 64'(mem_Arow), 64'd0);
      chk("rst_ain0", 64'(mem_Ain[0]), 64'd0);
      chk("rst_ain7", 64'(mem_Ain[7]), 64'd0);
      idle(1);

      // Back-to-back load, then rows offered in READY must be ignored.
      clr_counts();
      for (int r = 0; r < DIM; r++) send_row(mk_row(r), 1'b1, r);
      check_loaded("load");
      send_row(mk_row(9), 1'b0, 0);
      send_row(mk_row(10), 1'b0, 0);
      do_stream("stream1", 22);

      // Load with valid gaps of two cycles.
      clr_counts();
      for (int r = 0; r < DIM; r++) begin
         send_row(mk_row(r + 20), 1'b1, r);
         if (r < DIM - 1) idle(2);
      end
      check_loaded("gaps");
      do_stream("stream2", 22);

      // start while IDLE partway through a load is ignored.
      clr_counts();
      for (int r = 0; r < 3; r++) send_row(mk_row(r), 1'b1, r);
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(3);
      @(negedge clk);
      chk("idle_start_busy", 64'(busy), 64'd0);
      chk("idle_start_en", 64'(en_total), 64'd0);
      chk("idle_start_ready", 64'(in_ready), 64'd1);
      idle(1);
      for (int r = 3; r < DIM; r++) send_row(mk_row(r), 1'b1, r);
      check_loaded("resume");

      // Abort in stream cycle 10 with a concurrent row offer.
      clr_counts();
      start = 1'b1;
      idle(1);
      start = 1'b0;
      idle(9);
      clear = 1'b1;
      in_valid = 1'b1;
      in_data = mk_row(5);
      @(negedge clk);
      chk("clear_in_ready", 64'(in_ready), 64'd0);
      idle(1);
      clear = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("clear_en_drop", 64'(mem_en), 64'd0);
      chk("clear_busy", 64'(busy), 64'd0);
      idle(3);
      chk("clear_en_cycles", 64'(en_total), 64'd10);
      chk("clear_no_done", 64'(done_cnt), 64'd0);

      // Reload after abort starts at row 0; signed extremes pass untouched.
      clr_counts();
      send_row(64'hFF80FF80FF80FF80, 1'b1, 0);
      send_row(64'h80808080FFFFFFFF, 1'b1, 1);
      for (int r = 2; r < DIM; r++) send_row(mk_row(r), 1'b1, r);
      check_loaded("neg");
      do_stream("stream3", 22);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mem_load_ctrl.md
MEM_LOAD_CTRL -- requirements
Module: mem_load_ctrl

Interface
REQ-001 SHALL have parameter BITS_AB, default 8: signed element width.
REQ-002 SHALL have parameter DIM, default 8: matrix dimension (rows, columns); power of two, >= 2.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1: synchronous abort to IDLE.
REQ-006 SHALL have port in_valid, input, 1: upstream row valid.
REQ-007 SHALL have port in_ready, output, 1: row accepted when in_valid & in_ready.
REQ-008 SHALL have port in_data, input, DIM*BITS_AB: packed row; element j = in_data[j*BITS_AB +: BITS_AB], signed.
REQ-009 SHALL have port start, input, 1: single-cycle request to stream the loaded matrix.
REQ-010 SHALL have port busy, output, 1: high in LOAD-complete wait (READY) or STREAM.
REQ-011 SHALL have port done, output, 1: one-cycle pulse at end of STREAM.
REQ-012 SHALL have port mem_WrEn, output, 1: row write strobe to the A-matrix skew buffer.
REQ-013 SHALL have port mem_Arow, output, $clog2(DIM): row index of the current write.
REQ-014 SHALL have port mem_Ain, output, DIM x BITS_AB signed unpacked array: row data, element j from in_data element j.
REQ-015 SHALL have port mem_en, output, 1: shift enable to the skew buffer.

Function
REQ-016 SHALL implement FSM states IDLE, READY, STREAM.
REQ-017 IDLE: in_ready=1; each accepted row increments row counter rcnt (0..DIM-1).
REQ-018 Accepted row at cycle N SHALL appear at cycle N+1 as mem_WrEn=1, mem_Arow=rcnt value at N, and mem_Ain=unpacked in_data (1-cycle registered latency).
REQ-019 mem_WrEn SHALL be 0 in every cycle not following an accepted row.
REQ-020 Acceptance of row DIM-1 SHALL transition IDLE->READY and wrap rcnt to 0.
REQ-021 READY and STREAM: in_ready=0; in_valid SHALL be ignored.
REQ-022 start in READY SHALL transition to STREAM next cycle; start in IDLE or STREAM SHALL be ignored.
REQ-023 STREAM: mem_en=1 for exactly STREAM_LEN = 3*DIM-2 consecutive cycles, counted by a stream counter; mem_en=0 in all other states.
REQ-024 After the last STREAM cycle the FSM SHALL enter IDLE; done SHALL be 1 in that first IDLE cycle only.
REQ-025 mem_WrEn and mem_en SHALL never be 1 in the same cycle.
REQ-026 clear SHALL, in any state, force next-state IDLE, rcnt=0, stream counter=0, and suppress any pending mem_WrEn; done SHALL NOT pulse on clear.
REQ-027 clear and in_valid in the same cycle: row SHALL NOT be accepted (in_ready=0 while clear=1).
REQ-028 Element values SHALL pass unmodified; no arithmetic on data.

Reset
REQ-029 On rst: state=IDLE, rcnt=0, stream counter=0, in_ready=1 after the reset cycle, busy=0, done=0, mem_WrEn=0, mem_en=0, mem_Arow=0, mem_Ain all 0.
REQ-030 rst SHALL take priority over clear, start and in_valid.

Structure
REQ-031 The FSM state enum and STREAM_LEN derivation SHALL reside in a shared package used by the A-side and B-side loaders.
REQ-032 Row unpacking SHALL be a generate loop within the module; no sub-module is required.
REQ-033 The module SHALL be a direct upstream peer of memA: mem_* ports connect one-to-one to en, WrEn, Arow, Ain.

Verification
REQ-034 Reset, then 8 rows with row r elements = r*8+j: mem_WrEn 8 cycles, mem_Arow 0..7, mem_Ain[j]=r*8+j, then busy=1, in_ready=0.
REQ-035 Rows with in_valid gaps (valid 1,0,0,1...): exactly 8 writes, Arow contiguous 0..7, no write during gaps.
REQ-036 start in READY: mem_en high exactly 22 cycles (DIM=8), done pulses once on the following cycle, in_ready returns to 1.
REQ-037 start in IDLE after 3 rows: ignored; state remains IDLE, next row writes Arow=3.
REQ-038 clear asserted in stream cycle 10: mem_en drops next cycle, no done, next accepted row writes Arow=0.
REQ-039 Negative elements (-128, -1) on DIM=8, BITS_AB=8: mem_Ain carries 8'h80, 8'hFF unchanged.
